// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
//
// Multi-cycle sequencer for the 8-bit, 4-register CPU datapath. Each instruction
// runs through FETCH -> DECODE -> EXEC -> WB. Instructions are fetched from the
// instruction ROM with a request/valid handshake. The WB-cycle commit strobes
// gate the PC, register-file and data-memory writes.
//
// Optional feature macro: CPU_SEQ_BREAKPOINT_EN
//   When defined, a PC breakpoint (bp_en/bp_addr) stops execution at FETCH entry.
//   When undefined, bp_en/bp_addr are ignored and bp_hit is tied low.
//   The port list is the same in both builds.
//
// Ports
//   clk          in   system clock (divided CPU clock)
//   reset        in   synchronous, active-low reset
//   run          in   level: keep executing while high
//   step         in   pulse: execute exactly one instruction from IDLE
//   halt_req     in   pulse: stop once the current instruction has retired
//   pc_in        in   current PC value (the fetch address)
//   fetch_req    out  request to the instruction ROM
//   instr_valid  in   ROM response valid (looked at only while fetch_req=1)
//   instr_in     in   ROM response data
//   instr_out    out  instruction register (IR) that drives the datapath
//   pc_we        out  PC update strobe (WB only)
//   rf_we_gate   out  register-file write gate (WB only)
//   mem_we_gate  out  data-memory write gate (WB only)
//   state        out  IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 ERR=7
//   busy         out  high when state is neither IDLE nor ERR
//   fetch_err    out  sticky fetch-timeout flag
//   instr_count  out  count of retired instructions (wraps)
//   bp_en        in   breakpoint enable
//   bp_addr      in   breakpoint PC
//   bp_hit       out  sticky breakpoint flag
// -----------------------------------------------------------------------------
module cpu_seq_ctrl #(
  parameter int INSTR_W       = 8,
  parameter int ADDR_W        = 8,
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               fetch_req,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               pc_we,
  output logic               rf_we_gate,
  output logic               mem_we_gate,
  output logic [2:0]         state,
  output logic               busy,
  output logic               fetch_err,
  output logic [CNT_W-1:0]   instr_count,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  output logic               bp_hit
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  // The wait counter counts the FETCH cycles that have already passed without a
  // response. The cycle in which it holds FETCH_TIMEOUT-1 is therefore the last
  // FETCH cycle that is allowed.
  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t             cur_state;
  state_t             nxt_state;
  logic [INSTR_W-1:0] ir;
  logic [7:0]         wait_cnt;
  logic [CNT_W-1:0]   retired;
  logic               step_mode;
  logic               halt_pend;
  logic               run_hold;
  logic               err_flag;

  logic               ir_load;
  logic               start_step;
  logic               hold_set;
  logic               bp_stop;
  logic               commit;

  // ---------------------------------------------------------------------------
  // Breakpoint compare
  // ---------------------------------------------------------------------------
`ifdef CPU_SEQ_BREAKPOINT_EN
  // bp_check is high only in the first FETCH cycle after a WB. A FETCH that is
  // entered from IDLE never compares. This lets a resumed run execute the
  // instruction that sits at the breakpoint address.
  logic bp_check;
  logic bp_flag;

  assign bp_stop = bp_check && (cur_state == S_FETCH) && bp_en && (pc_in == bp_addr);
  assign bp_hit  = bp_flag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bp_check <= 1'b0;
      bp_flag  <= 1'b0;
    end else begin
      bp_check <= (cur_state == S_WB) && (nxt_state == S_FETCH);
      if (bp_stop)
        bp_flag <= 1'b1;
      else if ((cur_state == S_IDLE) && (nxt_state == S_FETCH))
        bp_flag <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{bp_en, bp_addr, pc_in};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state  = cur_state;
    ir_load    = 1'b0;
    start_step = 1'b0;
    hold_set   = 1'b0;
    case (cur_state)
      S_IDLE: begin
        // While run_hold is set, a run level that is still high from an earlier
        // halt or breakpoint is ignored. run must drop and rise again.
        if (run && !run_hold) begin
          nxt_state = S_FETCH;
        end else if (step) begin
          nxt_state  = S_FETCH;
          start_step = 1'b1;
        end
      end
      S_FETCH: begin
        if (bp_stop) begin
          nxt_state = S_IDLE;
          hold_set  = 1'b1;
        end else if (instr_valid) begin
          ir_load   = 1'b1;
          nxt_state = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt_state = S_ERR;
        end
      end
      S_DECODE: nxt_state = S_EXEC;
      S_EXEC:   nxt_state = S_WB;
      S_WB: begin
        // A halt_req seen in this same WB cycle counts as much as one that is
        // already pending.
        if (run && !step_mode && !halt_pend && !halt_req) begin
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_IDLE;
          hold_set  = halt_pend || halt_req;
        end
      end
      S_ERR:    nxt_state = S_ERR;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= S_IDLE;
      ir        <= '0;
      wait_cnt  <= '0;
      retired   <= '0;
      step_mode <= 1'b0;
      halt_pend <= 1'b0;
      run_hold  <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      cur_state <= nxt_state;

      if (ir_load)
        ir <= instr_in;

      if ((cur_state == S_FETCH) && (nxt_state == S_FETCH))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;

      if ((cur_state == S_IDLE) && (nxt_state == S_FETCH))
        step_mode <= start_step;

      if (nxt_state == S_IDLE)
        halt_pend <= 1'b0;
      else if (busy && halt_req)
        halt_pend <= 1'b1;

      if (hold_set)
        run_hold <= 1'b1;
      else if (!run)
        run_hold <= 1'b0;

      if (nxt_state == S_ERR)
        err_flag <= 1'b1;

      if (cur_state == S_WB)
        retired <= retired + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The commit strobes are also gated by reset. If reset is asserted during WB,
  // nothing is written at that edge.
  assign commit      = (cur_state == S_WB) && reset;
  assign pc_we       = commit;
  assign rf_we_gate  = commit;
  assign mem_we_gate = commit;

  assign fetch_req   = (cur_state == S_FETCH) && !bp_stop;
  assign instr_out   = ir;
  assign state       = cur_state;
  assign busy        = (cur_state != S_IDLE) && (cur_state != S_ERR);
  assign fetch_err   = err_flag;
  assign instr_count = retired;

endmodule
